// File: rtl/arm_shift_pkg.sv
// Shared types for the ARM addressing-mode-1 operand pipeline: mode codes,
// shift types and the stage-1 payload.
package arm_shift_pkg;

    typedef enum logic [2:0] {
        MODE_DPI     = 3'd0,
        MODE_DPIS    = 3'd1,
        MODE_DPRS    = 3'd2,
        MODE_LSIO    = 3'd3,
        MODE_LSHSBCO = 3'd4,
        MODE_BL      = 3'd5,
        MODE_PASS    = 3'd6,
        MODE_RSVD    = 3'd7
    } mode_t;

    typedef enum logic [1:0] {
        SH_LSL = 2'd0,
        SH_LSR = 2'd1,
        SH_ASR = 2'd2,
        SH_ROR = 2'd3
    } shift_t;

    // Everything stage 2 needs besides the operand source and the tag.
    typedef struct packed {
        mode_t      mode;
        shift_t     sh;
        logic [7:0] amt;
        logic       is_reg;
        logic       c;
    } s1_t;

endpackage

// File: rtl/shift_core.sv
// Combinational XLEN-wide barrel shifter implementing the ARM immediate and
// register shift special cases. Result is {carry, value}.
module shift_core
    import arm_shift_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  shift_t          i_type,
    input  logic [7:0]      i_amt,
    input  logic            i_is_reg,
    input  logic [XLEN-1:0] i_rm,
    input  logic            i_c,
    output logic [XLEN:0]   o_result
);

    logic [7:0]      w_n;
    logic            w_rrx;
    logic [31:0]     w_asr_n;
    logic [31:0]     w_ror_n;
    logic [XLEN:0]   w_lsl;
    logic [XLEN:0]   w_lsr;
    logic [XLEN:0]   w_asr;
    logic [XLEN-1:0] w_ror;

    // Immediate encodings map onto register semantics, except ROR #0 (RRX).
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
        w_n   = i_amt;
        w_rrx = 1'b0;
        if (!i_is_reg) begin
            w_n = {3'b000, i_amt[4:0]};
            if (i_amt[4:0] == 5'd0) begin
                if (i_type == SH_LSR || i_type == SH_ASR) begin
                    w_n = 8'd32;
                end
                w_rrx = (i_type == SH_ROR);
            end
        end
    end

    assign w_asr_n = (32'(w_n) >= 32'(XLEN)) ? 32'(XLEN) : 32'(w_n);
    assign w_ror_n = 32'(w_n) & 32'(XLEN - 1);

    // The extra bit on the far side of each shift catches the last bit shifted out.
    assign w_lsl = {1'b0, i_rm} << w_n;
    assign w_lsr = {i_rm, 1'b0} >> w_n;
    assign w_asr = $unsigned($signed({i_rm, 1'b0}) >>> w_asr_n);
    assign w_ror = (i_rm >> w_ror_n) | (i_rm << (32'(XLEN) - w_ror_n));

    always_comb begin
        o_result = {i_c, i_rm};
        if (w_rrx) begin
            o_result = {i_rm[0], i_c, i_rm[XLEN-1:1]};
        end else if (w_n != 8'd0) begin
            case (i_type)
                SH_LSL: o_result = w_lsl;
                SH_LSR: o_result = {w_lsr[0], w_lsr[XLEN:1]};
                SH_ASR: o_result = {w_asr[0], w_asr[XLEN:1]};
                SH_ROR: o_result = {w_ror[XLEN-1], w_ror};
            endcase
        end
    end

endmodule

// File: rtl/shifter_operand_pipe.sv
// Two-stage pipelined ARM addressing-mode-1 operand generator with a
// valid/ready handshake and an opaque tag travelling with each request.
module shifter_operand_pipe
    import arm_shift_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_mode,
    input  logic [31:0]      in_ir,
    input  logic [XLEN-1:0]  in_rm,
    input  logic [7:0]       in_rs_lsb,
    input  logic             in_c,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_operand,
    output logic             out_carry,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);

    s1_t              w_s1_next;
    logic [XLEN-1:0]  w_src_next;
    logic             w_s1_adv;
    logic             w_s2_adv;
    logic [XLEN:0]    w_core_result;
    logic             w_unused_ir;

    logic             r_s1_valid;
    s1_t              r_s1;
    logic [XLEN-1:0]  r_s1_src;
    logic [TAG_W-1:0] r_s1_tag;
    logic             r_s2_valid;
    logic [XLEN-1:0]  r_out_operand;
    logic             r_out_carry;
    logic [TAG_W-1:0] r_out_tag;
    logic             r_out_err;

    assign w_s2_adv    = !r_s2_valid || out_ready;
    assign w_s1_adv    = !r_s1_valid || w_s2_adv;
    assign in_ready    = w_s1_adv;
    assign w_unused_ir = ^{in_ir[31:24], in_ir[4]};

    // Non-shift modes become an LSL #0 register shift of a prepared source,
    // which yields the source unchanged with carry C.
    always_comb begin
        w_s1_next  = '{mode: mode_t'(in_mode), sh: SH_LSL, amt: 8'd0, is_reg: 1'b1, c: in_c};
        w_src_next = '0;
        case (mode_t'(in_mode))
            MODE_DPI: begin
                w_s1_next.sh  = SH_ROR;
                w_s1_next.amt = {3'b000, in_ir[11:8], 1'b0};
                w_src_next    = XLEN'(in_ir[7:0]);
            end
            MODE_DPIS: begin
                w_s1_next.sh     = shift_t'(in_ir[6:5]);
                w_s1_next.amt    = {3'b000, in_ir[11:7]};
                w_s1_next.is_reg = 1'b0;
                w_src_next       = in_rm;
            end
            MODE_DPRS: begin
                w_s1_next.sh  = shift_t'(in_ir[6:5]);
                w_s1_next.amt = in_rs_lsb;
                w_src_next    = in_rm;
            end
            MODE_LSIO:    w_src_next = XLEN'(in_ir[11:0]);
            MODE_LSHSBCO: w_src_next = XLEN'({in_ir[11:8], in_ir[3:0]});
            MODE_BL:      w_src_next = XLEN'(in_ir[23:0]);
            MODE_PASS:    w_src_next = in_rm;
            default:      w_src_next = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            r_s1_valid <= 1'b0;
            r_s1       <= '0;
            r_s1_src   <= '0;
            r_s1_tag   <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1     <= w_s1_next;
                r_s1_src <= w_src_next;
                r_s1_tag <= in_tag;
            end
        end
    end

    shift_core #(.XLEN(XLEN)) u_shift_core (
        .i_type   (r_s1.sh),
        .i_amt    (r_s1.amt),
        .i_is_reg (r_s1.is_reg),
        .i_rm     (r_s1_src),
        .i_c      (r_s1.c),
        .o_result (w_core_result)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid    <= 1'b0;
            r_out_operand <= '0;
            r_out_carry   <= 1'b0;
            r_out_tag     <= '0;
            r_out_err     <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_operand <= w_core_result[XLEN-1:0];
                r_out_carry   <= w_core_result[XLEN];
                r_out_tag     <= r_s1_tag;
                r_out_err     <= (r_s1.mode == MODE_RSVD);
            end
        end
    end

    assign out_valid   = r_s2_valid;
    assign out_operand = r_out_operand;
    assign out_carry   = r_out_carry;
    assign out_tag     = r_out_tag;
    assign out_err     = r_out_err;

endmodule

// File: tb/tb_shifter_operand_pipe.sv
// Directed self-checking bench for shifter_operand_pipe (XLEN=32, TAG_W=4).
module tb_shifter_operand_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_mode;
    logic [31:0] in_ir;
    logic [31:0] in_rm;
    logic [7:0]  in_rs_lsb;
    logic        in_c;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_operand;
    logic        out_carry;
    logic [3:0]  out_tag;
    logic        out_err;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [2:0]  mode;
        logic [31:0] ir;
        logic [31:0] rm;
        logic [7:0]  rs;
        logic        c;
        logic [31:0] op;
        logic        cy;
        logic        er;
    } vec_t;

    shifter_operand_pipe #(.XLEN(32), .TAG_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_mode     (in_mode),
        .in_ir       (in_ir),
        .in_rm       (in_rm),
        .in_rs_lsb   (in_rs_lsb),
        .in_c        (in_c),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_operand (out_operand),
        .out_carry   (out_carry),
        .out_tag     (out_tag),
        .out_err     (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic [2:0] mode, input logic [31:0] ir,
                                input logic [31:0] rm, input logic [7:0] rs, input logic c,
                                input logic [31:0] op, input logic cy, input logic er);
        vec_t v;
        v = '{mode: mode, ir: ir, rm: rm, rs: rs, c: c, op: op, cy: cy, er: er};
        return v;
    endfunction

    // Issues one request into an idle pipe and waits (bounded) for its result.
    task automatic run_op(input vec_t v, input logic [3:0] tag,
                          output logic [31:0] op, output logic cy,
                          output logic er, output logic [3:0] tg);
        bit seen;
        @(negedge clk);
        in_valid  = 1'b1;
        in_mode   = v.mode;
        in_ir     = v.ir;
        in_rm     = v.rm;
        in_rs_lsb = v.rs;
        in_c      = v.c;
        in_tag    = tag;
        out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            seen = out_valid;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL op_timeout: out_valid=0 after 8 cycles, required 1 (tag %0d)", tag);
        end
        op = out_operand;
        cy = out_carry;
        er = out_err;
        tg = out_tag;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_mode   = 3'd0;
        in_ir     = '0;
        in_rm     = '0;
        in_rs_lsb = '0;
        in_c      = 1'b0;
        in_tag    = '0;
        out_ready = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_operand !== 32'h0 || out_carry !== 1'b0 ||
            out_tag !== 4'h0 || out_err !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_values: got v=%b op=%h c=%b tag=%h err=%b rdy=%b, want 0 0 0 0 0 1",
                     out_valid, out_operand, out_carry, out_tag, out_err, in_ready);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL after_reset: got v=%b rdy=%b, want v=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_dpi();
        vec_t v[2];
        logic [31:0] op; logic cy, er; logic [3:0] tg;
        v[0] = mk(3'd0, 32'h0000_04FF, 32'h0, 8'd0, 1'b0, 32'hFF00_0000, 1'b1, 1'b0);
        v[1] = mk(3'd0, 32'h0000_00FF, 32'h0, 8'd0, 1'b1, 32'h0000_00FF, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            run_op(v[i], 4'(i + 1), op, cy, er, tg);
            checks++;
            if (op !== v[i].op || cy !== v[i].cy || er !== v[i].er) begin
                failures++;
                $display("FAIL dpi[%0d]: got op=%h c=%b err=%b, want op=%h c=%b err=%b",
                         i, op, cy, er, v[i].op, v[i].cy, v[i].er);
            end
        end
    endtask

    task automatic test_dpis();
        vec_t v[4];
        logic [31:0] op; logic cy, er; logic [3:0] tg;
        v[0] = mk(3'd1, 32'h0000_0060, 32'h0000_0003, 8'd0, 1'b1, 32'h8000_0001, 1'b1, 1'b0); // RRX
        v[1] = mk(3'd1, 32'h0000_0020, 32'h8000_0000, 8'd0, 1'b1, 32'h0000_0000, 1'b1, 1'b0); // LSR #32
        v[2] = mk(3'd1, 32'h0000_0200, 32'hF000_000F, 8'd0, 1'b0, 32'h0000_00F0, 1'b1, 1'b0); // LSL #4
        v[3] = mk(3'd1, 32'h0000_00C0, 32'h8000_0001, 8'd0, 1'b0, 32'hC000_0000, 1'b1, 1'b0); // ASR #1
        for (int i = 0; i < 4; i++) begin
            run_op(v[i], 4'(i + 3), op, cy, er, tg);
            checks++;
            if (op !== v[i].op || cy !== v[i].cy || er !== v[i].er) begin
                failures++;
                $display("FAIL dpis[%0d]: got op=%h c=%b err=%b, want op=%h c=%b err=%b",
                         i, op, cy, er, v[i].op, v[i].cy, v[i].er);
            end
        end
    endtask

    task automatic test_dprs();
        vec_t v[7];
        logic [31:0] op; logic cy, er; logic [3:0] tg;
        v[0] = mk(3'd2, 32'h0000_0000, 32'h0000_0001, 8'd32, 1'b0, 32'h0000_0000, 1'b1, 1'b0); // LSL 32
        v[1] = mk(3'd2, 32'h0000_0000, 32'h0000_0001, 8'd33, 1'b1, 32'h0000_0000, 1'b0, 1'b0); // LSL 33
        v[2] = mk(3'd2, 32'h0000_0000, 32'h0000_0001, 8'd0,  1'b1, 32'h0000_0001, 1'b1, 1'b0); // LSL 0
        v[3] = mk(3'd2, 32'h0000_0060, 32'h8000_0000, 8'd64, 1'b0, 32'h8000_0000, 1'b1, 1'b0); // ROR 64
        v[4] = mk(3'd2, 32'h0000_0060, 32'h0000_000F, 8'd4,  1'b0, 32'hF000_0000, 1'b1, 1'b0); // ROR 4
        v[5] = mk(3'd2, 32'h0000_0040, 32'h8000_0000, 8'd40, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0); // ASR 40
        v[6] = mk(3'd2, 32'h0000_0020, 32'h8000_0000, 8'd32, 1'b0, 32'h0000_0000, 1'b1, 1'b0); // LSR 32
        for (int i = 0; i < 7; i++) begin
            run_op(v[i], 4'(i + 7), op, cy, er, tg);
            checks++;
            if (op !== v[i].op || cy !== v[i].cy || er !== v[i].er) begin
                failures++;
                $display("FAIL dprs[%0d]: got op=%h c=%b err=%b, want op=%h c=%b err=%b",
                         i, op, cy, er, v[i].op, v[i].cy, v[i].er);
            end
        end
    endtask

    task automatic test_modes();
        vec_t v[5];
        logic [31:0] op; logic cy, er; logic [3:0] tg;
        v[0] = mk(3'd4, 32'h0000_0A05, 32'h1234_5678, 8'd0, 1'b1, 32'h0000_00A5, 1'b1, 1'b0); // LSHSBCO
        v[1] = mk(3'd5, 32'hEEAB_CDEF, 32'h1234_5678, 8'd0, 1'b0, 32'h00AB_CDEF, 1'b0, 1'b0); // BL
        v[2] = mk(3'd7, 32'hFFFF_FFFF, 32'h1234_5678, 8'd9, 1'b1, 32'h0000_0000, 1'b1, 1'b1); // reserved
        v[3] = mk(3'd3, 32'hFFFF_F123, 32'h1234_5678, 8'd0, 1'b0, 32'h0000_0123, 1'b0, 1'b0); // LSIO
        v[4] = mk(3'd6, 32'h0000_0000, 32'hDEAD_BEEF, 8'd5, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0); // PASS
        for (int i = 0; i < 5; i++) begin
            run_op(v[i], 4'(i + 10), op, cy, er, tg);
            checks++;
            if (op !== v[i].op || cy !== v[i].cy || er !== v[i].er || tg !== 4'(i + 10)) begin
                failures++;
                $display("FAIL mode[%0d]: got op=%h c=%b err=%b tag=%h, want op=%h c=%b err=%b tag=%h",
                         i, op, cy, er, tg, v[i].op, v[i].cy, v[i].er, 4'(i + 10));
            end
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        in_mode = 3'd6; in_c = 1'b1; in_ir = '0; in_rs_lsb = '0;
        in_valid = 1'b1; in_rm = 32'h1111_1111; in_tag = 4'd1; out_ready = 1'b1;
        @(negedge clk);
        in_rm = 32'h2222_2222; in_tag = 4'd2; out_ready = 1'b0;
        @(negedge clk);
        in_rm = 32'h3333_3333; in_tag = 4'd3;
        // Consumer stalled with both stages occupied: output must hold, input must block.
        for (int cyc = 0; cyc < 3; cyc++) begin
            checks++;
            if (out_valid !== 1'b1 || out_tag !== 4'd1 || out_operand !== 32'h1111_1111 ||
                out_carry !== 1'b1 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL b2b_stall[%0d]: got v=%b tag=%h op=%h c=%b rdy=%b, want 1 1 11111111 1 0",
                         cyc, out_valid, out_tag, out_operand, out_carry, in_ready);
            end
            if (cyc < 2) @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ready_comb: got in_ready=%b, want 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_tag !== 4'd2 || out_operand !== 32'h2222_2222) begin
            failures++;
            $display("FAIL b2b_second: got v=%b tag=%h op=%h, want 1 2 22222222", out_valid, out_tag, out_operand);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_tag !== 4'd3 || out_operand !== 32'h3333_3333) begin
            failures++;
            $display("FAIL b2b_third: got v=%b tag=%h op=%h, want 1 3 33333333", out_valid, out_tag, out_operand);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_drain: got out_valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_mode = 3'd6; in_c = 1'b0;
        in_rm = 32'hAAAA_5555; in_tag = 4'h9;
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_prefill: got v=%b rdy=%b, want v=1 rdy=0", out_valid, in_ready);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_tag !== 4'h0) begin
            failures++;
            $display("FAIL rst_async: got v=%b rdy=%b tag=%h, want 0 1 0", out_valid, in_ready, out_tag);
        end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_discard: got out_valid=%b, want 0", out_valid);
        end
        in_valid = 1'b1; in_rm = 32'h0000_1234; in_tag = 4'h5; in_c = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL post_rst_edge1: got out_valid=%b, want 0", out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_operand !== 32'h0000_1234 || out_tag !== 4'h5 || out_carry !== 1'b1) begin
            failures++;
            $display("FAIL post_rst_edge2: got v=%b op=%h tag=%h c=%b, want 1 00001234 5 1",
                     out_valid, out_operand, out_tag, out_carry);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_dpi();
        test_dpis();
        test_dprs();
        test_modes();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
